lif_neuron_updater: RTL

Timestep sequencer for the leaky integrate-and-fire (LIF) neuron array. It walks every membrane-potential word held in the neighbouring `sram` instance, one neuron at a time. For each neuron it reads the potential, applies leak and the neuron's input current, compares the result with the threshold, emits a spike event if the threshold is reached, and writes the new potential back. It drives the SRAM's address, write-enable and write-word ports directly and consumes its registered read word.

---
 rtl/lif_pkg.sv | 32 +++
 rtl/lif_update_datapath.sv | 28 ++
 rtl/lif_neuron_updater.sv | 113 +++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron timestep sequencer.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMPUTE,
        DONE
    } lif_state_t;

    // Saturates a + b into a signed w-bit range; operands must already fit well inside 64 bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_update_datapath.sv
// Combinational leak / integrate / saturate / threshold step for a single neuron.
module lif_update_datapath
    import lif_pkg::*;
#(
    parameter int unsigned              WIDTH      = 32,
    parameter logic signed [WIDTH-1:0]  THRESHOLD  = 65536,
    parameter logic signed [WIDTH-1:0]  V_RESET    = 0,
    parameter int unsigned              LEAK_SHIFT = 4
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] current,
    output logic signed [WIDTH-1:0] new_v,
    output logic                    spike
);

    logic signed [WIDTH+1:0] v_ext;
    logic signed [WIDTH+1:0] leaked;
    logic signed [63:0]      sat;

    always_comb begin
        v_ext  = (WIDTH + 2)'(v);
        leaked = v_ext - (v_ext >>> LEAK_SHIFT);
        sat    = sat_add(64'(leaked), 64'(current), WIDTH);
        spike  = (sat >= 64'(THRESHOLD));
        new_v  = spike ? V_RESET : sat[WIDTH-1:0];
    end

endmodule

// File: rtl/lif_neuron_updater.sv
// Timestep sequencer: walks every neuron potential in SRAM, updates it and emits spike events.
module lif_neuron_updater
    import lif_pkg::*;
#(
    parameter int unsigned              WIDTH      = 32,
    parameter int unsigned              DEPTH      = 256,
    parameter logic signed [WIDTH-1:0]  THRESHOLD  = 65536,
    parameter logic signed [WIDTH-1:0]  V_RESET    = 0,
    parameter int unsigned              LEAK_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_current,
    output logic                        in_ready,
    output logic [$clog2(DEPTH)-1:0]    mem_addr,
    output logic                        mem_write_enable,
    output logic signed [WIDTH-1:0]     mem_write_word,
    input  logic signed [WIDTH-1:0]     mem_word,
    output logic                        spike_valid,
    output logic [$clog2(DEPTH)-1:0]    spike_id,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    lif_state_t              state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic                    spike_valid_q, spike_valid_d;
    logic [AW-1:0]           spike_id_q, spike_id_d;
    logic                    handshake;
    logic                    dp_spike;
    logic signed [WIDTH-1:0] dp_new_v;

    lif_update_datapath #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .V_RESET    (V_RESET),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_datapath (
        .v       (mem_word),
        .current (in_current),
        .new_v   (dp_new_v),
        .spike   (dp_spike)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        spike_valid_d = handshake && dp_spike;
        spike_id_d    = (handshake && dp_spike) ? idx_q : spike_id_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = COMPUTE;
            end
            COMPUTE: begin
                // Without a handshake the address and state simply hold, however long.
                if (in_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready         = (state_q == COMPUTE);
        handshake        = in_ready && in_valid;
        mem_write_enable = handshake;
        mem_write_word   = handshake ? dp_new_v : '0;
        mem_addr         = idx_q;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        spike_valid      = spike_valid_q;
        spike_id         = spike_id_q;
    end

endmodule
